// File: rtl/text_console_buffer.sv
// text_console_buffer: scrolling character/attribute frame store feeding the glyph renderer
module text_console_buffer #(
    parameter int         COLUMNS           = 80,
    parameter int         ROWS              = 30,
    parameter logic [7:0] DEFAULT_ATTRIBUTE = 8'h0F,
    parameter logic [7:0] BLANK_CODEPOINT   = 8'h20
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [7:0] char_data,
    input  logic [7:0] char_attribute,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic [7:0] codepoint,
    output logic [7:0] attribute,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);

    localparam int CELLS = COLUMNS * ROWS;
    localparam int AW = $clog2(CELLS);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_FILL = AW'(COLUMNS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, FILL} state_t;

    function automatic logic [4:0] phys_row(input logic [4:0] r, input logic [4:0] top);
        logic [5:0] s;
        s = {1'b0, r} + {1'b0, top};
        return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
        return AW'(int'(r) * COLUMNS + int'(c));
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   fill_base_q, fill_base_d;
    logic [6:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic [4:0]      top_q, top_d;
    logic            char_ready_q, char_ready_d;
    logic            busy_q, busy_d;
    logic            advance;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [15:0]     wdata;

    logic [15:0]     mem [CELLS];
    logic [15:0]     rd_data_q;
    logic            oob_q, oob_d;
    logic [AW-1:0]   rd_addr;
    logic            unused_bits;

    assign unused_bits = ^{cx[2:0], cy[3:0], cy[9]};

    // Map the pixel position to a cell through the scroll offset; off-screen cells read blank
    always_comb begin
        oob_d = (cx[9:3] >= 7'(COLUMNS)) || (cy[8:4] >= 5'(ROWS));
        rd_addr = oob_d ? '0 : cell_addr(phys_row(cy[8:4], top_q), cx[9:3]);
    end

    // Cell store: one write port, one registered read-first port
    always_ff @(posedge clk_pixel) begin
        if (we) mem[waddr] <= wdata;
        rd_data_q <= mem[rd_addr];
    end

    // Off-screen flag resets high so the outputs come up as blank with a zero attribute
    always_ff @(posedge clk_pixel) begin
        if (reset) oob_q <= 1'b1;
        else oob_q <= oob_d;
    end

    assign codepoint = oob_q ? BLANK_CODEPOINT : rd_data_q[15:8];
    assign attribute = oob_q ? 8'h00 : rd_data_q[7:0];

    // Sequencer: clear sweep, idle byte interpretation, and bottom-row fill after a scroll
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        fill_base_d = fill_base_q;
        col_d = col_q;
        row_d = row_q;
        top_d = top_q;
        we = 1'b0;
        waddr = cnt_q;
        wdata = {BLANK_CODEPOINT, DEFAULT_ATTRIBUTE};
        advance = 1'b0;
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                state_d = (cnt_q == LAST_CELL) ? IDLE : CLEAR;
                cnt_d = (cnt_q == LAST_CELL) ? '0 : cnt_q + AW'(1);
            end
            FILL: begin
                we = 1'b1;
                waddr = fill_base_q + cnt_q;
                state_d = (cnt_q == LAST_FILL) ? IDLE : FILL;
                cnt_d = (cnt_q == LAST_FILL) ? '0 : cnt_q + AW'(1);
            end
            IDLE: begin
                if (char_valid && char_ready_q) begin
                    case (char_data)
                        8'h0D: col_d = 7'd0;
                        8'h0A: advance = 1'b1;
                        8'h08: col_d = (col_q != 7'd0) ? col_q - 7'd1 : col_q;
                        8'h0C: begin
                            col_d = 7'd0;
                            row_d = 5'd0;
                            top_d = 5'd0;
                            cnt_d = '0;
                            state_d = CLEAR;
                        end
                        default: begin
                            we = 1'b1;
                            waddr = cell_addr(phys_row(row_q, top_q), col_q);
                            wdata = {char_data, char_attribute};
                            advance = (col_q == LAST_COL);
                            col_d = (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
                        end
                    endcase
                    if (advance) begin
                        if (row_q != LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            top_d = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
                            fill_base_d = cell_addr(top_q, 7'd0);
                            cnt_d = '0;
                            state_d = FILL;
                        end
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        char_ready_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    // State registers; reset restarts the clear sweep from address 0
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            fill_base_q <= '0;
            col_q <= 7'd0;
            row_q <= 5'd0;
            top_q <= 5'd0;
            char_ready_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            fill_base_q <= fill_base_d;
            col_q <= col_d;
            row_q <= row_d;
            top_q <= top_d;
            char_ready_q <= char_ready_d;
            busy_q <= busy_d;
        end
    end

    assign char_ready = char_ready_q;
    assign busy = busy_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: doc/text_console_buffer.md
Name: text_console_buffer

Overview:
- Character/attribute frame store that feeds the console glyph renderer.
- Accepts a byte stream on a valid/ready handshake, interprets a small control-character set, and maintains a cursor and a scrolling circular screen buffer.
- Returns the codepoint and attribute for the pixel position (cx, cy) supplied by the HDMI timing generator.
- Lives entirely in the clk_pixel domain.

Parameters:
- COLUMNS, 80, text columns per screen (cell width 8 px)
- ROWS, 30, text rows per screen (cell height 16 px)
- DEFAULT_ATTRIBUTE, 8'h0F, attribute written by clear and scroll fill
- BLANK_CODEPOINT, 8'h20, codepoint written by clear, scroll fill, and out-of-area reads

Ports:
- clk_pixel  input  1  pixel clock; the only clock
- reset  input  1  synchronous, active-high
- char_valid  input  1  write byte offered
- char_ready  output  1  block accepts the byte this cycle
- char_data  input  8  byte (printable or control)
- char_attribute  input  8  attribute stored with printable bytes
- cx  input  10  current pixel x
- cy  input  10  current pixel y
- codepoint  output  8  cell codepoint for (cx, cy), one-cycle latency
- attribute  output  8  cell attribute for (cx, cy), one-cycle latency
- cursor_col  output  7  current cursor column, 0..COLUMNS-1
- cursor_row  output  5  current cursor row in screen coordinates, 0..ROWS-1
- busy  output  1  clear or scroll fill in progress

Behaviour:
- Storage: COLUMNS*ROWS cells of {codepoint, attribute}, 16 bits each. One write port and one read port; maps to block RAM.
- Physical row index = (screen row + top_row) mod ROWS, where top_row is the circular scroll offset.
- Reset (sampled on a clk_pixel edge with reset=1):
  - cursor_col=0, cursor_row=0, top_row=0.
  - codepoint=BLANK_CODEPOINT, attribute=8'h00.
  - char_ready=0, busy=1.
  - FSM enters CLEAR.
- FSM states: CLEAR, IDLE, FILL.
  - CLEAR: writes {BLANK_CODEPOINT, DEFAULT_ATTRIBUTE} to one cell per cycle, address 0..COLUMNS*ROWS-1. Takes exactly COLUMNS*ROWS cycles, then goes to IDLE.
  - IDLE: char_ready=1, busy=0. A transfer occurs when char_valid && char_ready.
  - FILL: blanks the new bottom physical row, COLUMNS cycles, one cell per cycle, then goes to IDLE.
- char_ready is 1 only in IDLE; it is registered from FSM state, so it never depends combinationally on char_valid.
- Byte interpretation on a transfer:
  - 8'h0D (CR): cursor_col=0.
  - 8'h0A (LF): line advance.
  - 8'h08 (BS): if cursor_col>0, cursor_col-1; no cell write. At column 0 it does nothing and does not move up a row.
  - 8'h0C (FF): cursor to (0,0), top_row=0, enter CLEAR.
  - Any other byte: write {char_data, char_attribute} at the cursor, then cursor_col+1. If cursor_col was COLUMNS-1: cursor_col=0 and line advance.
- Line advance:
  - If cursor_row<ROWS-1: cursor_row+1.
  - Else: top_row=(top_row+1) mod ROWS, cursor_row stays ROWS-1, enter FILL on the physical row that has just become the bottom screen row.
- Read path:
  - Cell column = cx[9:3], cell row = cy[8:4].
  - If cell column >= COLUMNS or cell row >= ROWS: output {BLANK_CODEPOINT, 8'h00}.
  - Otherwise output the stored cell.
  - Outputs are registered with exactly 1 cycle of latency from cx/cy.
  - The read path is independent of FSM state: it keeps running during CLEAR and FILL.
- Read/write collision: if the displayed cell is written in the same cycle, read returns the old value (read-first). No stall.
- Reset asserted mid-FILL or mid-CLEAR: cursor and top_row are reinitialised and CLEAR restarts from address 0.
- Arithmetic:
  - All mod-ROWS and mod-COLUMNS wraps use compare-and-reset; no modulo operators.
  - Cell address = phys_row*COLUMNS + col, width clog2(COLUMNS*ROWS).

Test Plan:
- Reset, then hold char_valid=0 → busy=1 and char_ready=0 for exactly 2400 cycles, then char_ready=1. Every in-area cell reads 8'h20/8'h0F; cx=700 reads 8'h20/8'h00.
- Send 'A' (8'h41, attr 8'h1E) from the home position → cursor_col=1. Drive cx=0..7, cy=0..15 → codepoint=8'h41, attribute=8'h1E one cycle after each cx/cy.
- Send 80 printable bytes from column 0 → cursor wraps to (col 0, row 1). Row 0 col 79 holds the 80th byte.
- Cursor at row 29; send LF → top_row=1, busy=1 for 80 cycles, char_ready=0 throughout. Screen row 29 reads all 8'h20/8'h0F afterwards; old screen row 1 content now appears at cy=0..15.
- Cursor at col 0; send BS → cursor unchanged. Send 'x', BS, CR → cursor_col=0, and the 'x' cell is still displayed.
- Assert reset for 1 cycle during FILL at fill cycle 40 → cursor=(0,0), top_row=0, full 2400-cycle CLEAR follows; no partially filled row remains.
